fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, which sets the width of the FIFO read data and the stream data.
REQ-002 SHALL have parameter BURST_LEN, default 4, which sets the beats per burst (legal range 2..256).
REQ-003 SHALL have a single clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  when high, the block may issue new FIFO reads.
REQ-007 fifo_empty  input  1  empty flag from the upstream FIFO.
REQ-008 fifo_data  input  DATA_WIDTH  FIFO read data, valid on the cycle after the FIFO samples fifo_rd_en high.
REQ-009 fifo_rd_en  output  1  pop request to the upstream FIFO; combinational from registered state and fifo_empty.
REQ-010 m_valid  output  1  stream data valid.
REQ-011 m_ready  input  1  downstream accept.
REQ-012 m_data  output  DATA_WIDTH  stream data, taken from the head of the output buffer.
REQ-013 m_last  output  1  marks the final beat of each burst.
REQ-014 word_count  output  16  count of completed stream handshakes; wraps from 0xFFFF to 0.

Function
REQ-015 SHALL hold a 2-entry output buffer: occupancy occ (0..2), an inflight flag, and a head/tail order that is first in, first out.
REQ-016 The stream handshake (pop) SHALL be defined as m_valid && m_ready.
REQ-017 fifo_rd_en SHALL be 1 iff all of the following hold: !rst, enable, !fifo_empty, and occ + inflight - pop <= 1.
REQ-018 inflight SHALL be set on the next edge to the value fifo_rd_en had in the current cycle.
REQ-019 When inflight=1, fifo_data SHALL be written to the buffer tail on that edge.
REQ-020 A pop SHALL remove the head entry; a simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-021 The buffer SHALL never overflow; a capture when occ=2 and pop=0 is unreachable and SHALL be asserted against in verification.
REQ-022 m_valid SHALL equal (occ != 0), and m_data SHALL be the head entry.
REQ-023 While m_valid=1 and m_ready=0, m_data and m_last SHALL remain stable.
REQ-024 Sustained throughput SHALL be 1 beat/cycle when fifo_empty=0, enable=1 and m_ready=1.
REQ-025 First-beat latency: fifo_rd_en issued in cycle N -> m_valid=1 in cycle N+1.
REQ-026 A beat counter beat (0..BURST_LEN-1) SHALL increment on each pop and wrap to 0 after BURST_LEN-1.
REQ-027 m_last SHALL equal m_valid && (beat == BURST_LEN-1).
REQ-028 word_count SHALL increment by 1 on each pop.
REQ-029 Deasserting enable SHALL stop new reads only; in-flight and buffered data SHALL still drain.
REQ-030 Deasserting enable SHALL NOT reset beat; bursts may span enable gaps.
REQ-031 fifo_empty rising while inflight=1 SHALL still capture the in-flight word; no further reads SHALL be issued.

Reset
REQ-032 Asserting rst SHALL immediately (asynchronously) set occ=0, inflight=0, beat=0, word_count=0, m_valid=0, m_last=0, m_data=0 and force fifo_rd_en=0.
REQ-033 Reset mid-burst SHALL discard buffered and in-flight data; the first beat after release SHALL have beat=0.
REQ-034 After rst deasserts, the first fifo_rd_en SHALL NOT occur before the first rising edge of clk.

Verification
REQ-035 Streaming: FIFO preloaded with 0x01..0x08, enable=1, m_ready=1 -> fifo_rd_en high for 8 consecutive cycles; m_data 0x01..0x08 on consecutive cycles; m_last on 0x04 and 0x08; word_count=8.
REQ-036 Backpressure: m_ready=0 for 5 cycles during streaming -> occ reaches 2, fifo_rd_en=0, m_data stable; after m_ready=1 the order is intact and no word is lost or duplicated.
REQ-037 Enable gap: enable=0 after 2 beats, held 4 cycles -> at most 2 further beats drain, then m_valid=0; resuming gives beat=2 continuity and m_last on the 4th beat.
REQ-038 Empty boundary: FIFO holding a single word 0xA5 -> exactly one fifo_rd_en, then m_data=0xA5 with m_valid for one handshake, then m_valid=0.
REQ-039 Reset mid-burst: rst pulsed asynchronously between clock edges after 3 beats -> all outputs 0 immediately; the next burst's m_last is on its 4th beat.
REQ-040 Wrap: 65536 handshakes -> word_count returns to 0x0000.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Reads words from an upstream first-word-fall-through-less FIFO (one-cycle read latency)
// and presents them as a valid/ready stream with burst framing and a handshake counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           word_count
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic                  run_q,        run_d;
  logic [1:0]            occ_q,        occ_d;
  logic                  inflight_q,   inflight_d;
  logic                  head_q,       head_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [BEAT_W-1:0]     beat_q,       beat_d;
  logic [15:0]           word_count_q, word_count_d;

  logic       pop;
  logic       tail;
  logic [2:0] fill;

  assign m_valid    = (occ_q != 2'd0);
  assign pop        = m_valid && m_ready;
  assign m_data     = buf_q[head_q];
  assign m_last     = m_valid && (beat_q == BEAT_MAX);
  assign word_count = word_count_q;

  // Slots committed after this edge: buffered + arriving - leaving. A new read is
  // only issued when it is guaranteed a slot, so the buffer can never overflow.
  assign fill = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};

  // run_q holds off the first read until one clock edge after reset release.
  assign fifo_rd_en = !rst && run_q && enable && !fifo_empty && (fill <= 3'd1);

  // A capture only happens with occ <= 1, so the tail is head + occ modulo 2.
  assign tail = head_q ^ occ_q[0];

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    run_d        = 1'b1;
    occ_d        = occ_q;
    inflight_d   = fifo_rd_en;
    head_d       = head_q;
    buf_d        = buf_q;
    beat_d       = beat_q;
    word_count_d = word_count_q;

    if (inflight_q) begin
      buf_d[tail] = fifo_data;
    end

    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    if (pop) begin
      head_d       = ~head_q;
      beat_d       = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
      word_count_d = word_count_q + 16'd1;
    end
  end

  // NOTE: the two buffer entries are reset as well, since m_data must read 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q        <= 1'b0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      head_q       <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      beat_q       <= '0;
      word_count_q <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      run_q        <= run_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      buf_q        <= buf_d;
      beat_q       <= beat_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench: an upstream FIFO model feeds the DUT, every word read is
// queued as expected output, and a monitor checks each stream handshake in order.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [15:0]   word_count;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] src_q [$];   // upstream FIFO contents
  logic [DW-1:0] exp_q [$];   // words read from the FIFO, not yet handed downstream
  logic [DW-1:0] pending;
  bit            pending_valid = 1'b0;
  int            beat_m   = 0;
  int            hs_total = 0;
  int            rd_cnt   = 0;
  int            hs_drv   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then observe what the next edge does.
  task automatic cycle(input bit en, input bit rdy);
    @(negedge clk);
    enable  = en;
    m_ready = rdy;
    fifo_data = pending_valid ? pending : DW'($urandom);
    pending_valid = 1'b0;
    fifo_empty = (src_q.size() == 0);
    #1;
    if (fifo_rd_en) begin
      if (src_q.size() == 0) begin
        check("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
      end else begin
        pending = src_q.pop_front();
        pending_valid = 1'b1;
        exp_q.push_back(pending);
        rd_cnt++;
        check("no_overflow", 32'(exp_q.size() <= ((m_valid && m_ready) ? 3 : 2)), 32'd1);
      end
    end
    if (m_valid && m_ready) hs_drv++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_m_valid",    32'(m_valid),    32'd0);
    check("rst_m_last",     32'(m_last),     32'd0);
    check("rst_m_data",     32'(m_data),     32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_rd_en",      32'(fifo_rd_en), 32'd0);
    exp_q.delete();
    pending_valid = 1'b0;
    beat_m   = 0;
    hs_total = 0;
    rd_cnt   = 0;
    hs_drv   = 0;
    @(negedge clk);
    enable     = 1'b1;
    m_ready    = 1'b1;
    fifo_empty = (src_q.size() == 0);
    #3;
    rst = 1'b0;
    #1;
    check("rd_en_before_first_edge", 32'(fifo_rd_en), 32'd0);
  endtask

  // Monitor: every handshake must carry the oldest outstanding word with correct framing.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("m_data",     32'(m_data),     32'(e));
          check("m_last",     32'(m_last),     32'(beat_m == BL - 1));
          check("word_count", 32'(word_count), 32'(hs_total & 32'hFFFF));
        end
        beat_m = (beat_m + 1) % BL;
        hs_total++;
      end
    end
  end

  initial begin
    int first_rd, last_rd, first_hs, last_hs, n_hs, g0;
    logic [DW-1:0] held_data;
    logic          held_last;

    // Streaming: 0x01..0x08 back to back
    pulse_reset();
    for (int i = 1; i <= 8; i++) src_q.push_back(DW'(i));
    first_rd = -1; last_rd = -1; first_hs = -1; last_hs = -1; n_hs = 0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b1);
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
      end
      if (m_valid && m_ready) begin
        if (first_hs < 0) first_hs = i;
        last_hs = i;
        n_hs++;
      end
    end
    check("stream_rd_count",   32'(rd_cnt),            32'd8);
    check("stream_rd_span",    32'(last_rd - first_rd), 32'd7);
    check("stream_hs_count",   32'(n_hs),              32'd8);
    check("stream_hs_span",    32'(last_hs - first_hs), 32'd7);
    check("stream_word_count", 32'(word_count),        32'd8);

    // Backpressure: five stalled cycles mid-stream
    pulse_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(DW'(8'h10 + i));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    held_data = '0; held_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 0) begin
        held_data = m_data;
        held_last = m_last;
      end
    end
    check("bp_m_valid",     32'(m_valid),      32'd1);
    check("bp_rd_en",       32'(fifo_rd_en),   32'd0);
    check("bp_outstanding", 32'(exp_q.size()), 32'd2);
    check("bp_data_stable", 32'(m_data),       32'(held_data));
    check("bp_last_stable", 32'(m_last),       32'(held_last));
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1);
    check("bp_drained", 32'(exp_q.size() + src_q.size()), 32'd0);
    check("bp_hs_total", 32'(hs_drv), 32'd8);

    // Enable gap after two beats
    pulse_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(DW'(8'h20 + i));
    for (int i = 0; i < 12 && hs_drv < 2; i++) cycle(1'b1, 1'b1);
    check("gap_reached_two", 32'(hs_drv >= 2), 32'd1);
    g0 = hs_drv;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    check("gap_drain_le2", 32'(hs_drv - g0 <= 2), 32'd1);
    check("gap_m_valid",   32'(m_valid),         32'd0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
    check("gap_drained", 32'(exp_q.size() + src_q.size()), 32'd0);

    // Single word in the FIFO
    pulse_reset();
    src_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    check("single_rd_count", 32'(rd_cnt),  32'd1);
    check("single_hs_count", 32'(hs_drv),  32'd1);
    check("single_m_valid",  32'(m_valid), 32'd0);

    // Reset in the middle of a burst
    pulse_reset();
    for (int i = 0; i < 12; i++) src_q.push_back(DW'(8'h30 + i));
    for (int i = 0; i < 12 && hs_drv < 3; i++) cycle(1'b1, 1'b1);
    check("midrst_reached_three", 32'(hs_drv >= 3), 32'd1);
    pulse_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1);
    check("midrst_drained", 32'(exp_q.size() + src_q.size()), 32'd0);

    // Random traffic
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 3) != 0 && src_q.size() < 64) src_q.push_back(DW'($urandom));
      cycle(($urandom % 10) != 0, ($urandom % 10) < 7);
    end
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1);
    check("rand_drained", 32'(exp_q.size() + src_q.size()), 32'd0);

    // Counter wrap after 65536 handshakes
    pulse_reset();
    for (int i = 0; i < 65536; i++) src_q.push_back(DW'($urandom));
    for (int i = 0; i < 66000 && hs_drv < 65536; i++) cycle(1'b1, 1'b1);
    check("wrap_hs_count", 32'(hs_drv), 32'd65536);
    cycle(1'b0, 1'b0);
    check("wrap_word_count", 32'(word_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
